laser_rx_deframer: RTL and testbench
====================================

Name: laser_rx_deframer

Overview:
- Sits between LaserReceiver (`data_valid`/`data_in` byte stream) and the FTDI write-queue request port (`wrreq`/`data_wr`/`wrq_full`).
- Parses framed packets from the laser link, buffers the payload, and checks an XOR checksum.
- Releases a payload to the FTDI queue only when its checksum matches, and flags ack/fail/close events for the top-level handshake FSM.

Parameters:
- MAX_PAYLOAD, 64, buffer depth in bytes and largest legal length field.
- TIMEOUT, 1024, idle clock cycles allowed between bytes inside a frame before the frame is aborted.
- START_BYTE, 8'hCC, frame start marker.
- CLOSE_BYTE, 8'h22, link-close marker.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  block enable. When 0, the block is forced to IDLE and input is ignored.
- data_valid  in  1  one-cycle strobe; `data_in` is valid in that cycle.
- data_in  in  8  received byte.
- wrq_full  in  1  FTDI write queue full.
- wrreq  out  1  registered write request to the FTDI queue.
- data_wr  out  8  registered byte accompanying `wrreq`.
- ack_pulse  out  1  one-cycle pulse: frame accepted.
- fail_pulse  out  1  one-cycle pulse: frame rejected (bad length, bad checksum or timeout).
- close_seen  out  1  one-cycle pulse: CLOSE_BYTE received while in IDLE.
- busy  out  1  high in every state except IDLE.
- err_count  out  8  saturating error counter. Tied to 0 without the optional feature.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - All outputs go to 0.
  - Write index, read index, length, checksum and timeout counter go to 0.
  - Buffer contents are don't-care.
- Frame format: START_BYTE, L, then L payload bytes, then C.
  - L must be in 1..MAX_PAYLOAD.
  - C = L ^ p0 ^ … ^ p(L-1).
- States: IDLE, LEN, PAYLOAD, CHECK, DRAIN.
- IDLE
  - `data_valid` with START_BYTE: go to LEN and clear the timeout counter.
  - `data_valid` with CLOSE_BYTE: pulse `close_seen` the next cycle and stay in IDLE.
  - Any other byte is discarded.
- LEN (on `data_valid`)
  - L = 0 or L > MAX_PAYLOAD: pulse `fail_pulse`, go to IDLE.
  - Otherwise: latch L, set checksum = L, set write index = 0, go to PAYLOAD.
- PAYLOAD (on `data_valid`)
  - Write buf[write index] = byte, XOR the byte into the checksum, increment the write index.
  - After the L-th byte, go to CHECK.
- CHECK (on `data_valid`)
  - Byte equals checksum: pulse `ack_pulse`, set read index = 0, go to DRAIN.
  - Otherwise: pulse `fail_pulse`, go to IDLE; the buffered payload is discarded.
- DRAIN
  - On every cycle with `wrq_full` = 0: the next cycle has `wrreq` = 1 and `data_wr` = buf[read index], and the read index increments.
  - When `wrq_full` = 1: `wrreq` = 0 the next cycle and the read index holds.
  - After the L-th request: return to IDLE.
  - `data_valid` bytes arriving in DRAIN are dropped; each one is counted as an overrun error.
- Timeout (LEN, PAYLOAD, CHECK only)
  - The counter increments every cycle without `data_valid` and clears on `data_valid`.
  - Reaching TIMEOUT: pulse `fail_pulse`, go to IDLE.
- Latency
  - `ack_pulse`/`fail_pulse`/`close_seen` assert exactly 1 cycle after the deciding `data_valid` cycle.
  - First `wrreq` asserts 2 cycles after the checksum byte, given `wrq_full` = 0.
- `ack_pulse` and `fail_pulse` are never high together. Each pulse lasts exactly one cycle.
- `en` deasserted mid-frame or mid-drain: go to IDLE next cycle, emit no pulses, and drop any undrained bytes.
- Widths:
  - Indices are $clog2(MAX_PAYLOAD+1) bits.
  - The timeout counter is $clog2(TIMEOUT+1) bits.
  - No wrap-around is possible, because L ≤ MAX_PAYLOAD.

Optional Feature:
- Macro: LASER_RX_DEFRAMER_STATS_EN.
- Defined: `err_count` increments by 1 on each of the following, saturating at 8'hFF and clearing only on reset:
  - every `fail_pulse`;
  - every dropped DRAIN byte.
  - If both events occur in the same cycle, the counter increments once.
- Undefined: `err_count` is a constant 0 and no counter logic is built.

Test Plan:
- Good frame: CC 03 11 22 33 03 → `ack_pulse` 1 cycle after the last byte; `wrreq` ×3 with `data_wr` 11, 22, 33; `fail_pulse` never high.
- Bad checksum: CC 03 11 22 33 04 → `fail_pulse` once; no `wrreq`; `busy` = 0 the cycle after the pulse; `err_count` = 1 with the macro.
- Length checks:
  - CC 00 → `fail_pulse`.
  - CC 41 (65 > 64) → `fail_pulse`.
  - The following CC 01 5A 5B → `ack_pulse` and a single `wrreq` with `data_wr` 5A.
- Backpressure: good 4-byte frame with `wrq_full` high for 10 cycles mid-drain → no `wrreq` during those cycles (plus 1 registered cycle); bytes are emitted in order with none lost or duplicated.
- Timeout: CC 02 AA, then 1024 idle cycles → `fail_pulse` at TIMEOUT; the next frame parses normally.
- Close and reset:
  - 22 in IDLE → `close_seen` pulse.
  - Synchronous reset asserted in PAYLOAD → next cycle all outputs are 0, state is IDLE, and no ack/fail pulse is emitted.

Source files
------------

// File: rtl/laser_rx_deframer_if.sv
// Byte-stream and write-queue signals between the laser receiver, the deframer and the FTDI queue.
// master drives the receive side and the queue status; slave is the deframer.
interface laser_rx_deframer_if;
  logic       en;
  logic       data_valid;
  logic [7:0] data_in;
  logic       wrq_full;
  logic       wrreq;
  logic [7:0] data_wr;

  modport master (
    output en, data_valid, data_in, wrq_full,
    input  wrreq, data_wr
  );

  modport slave (
    input  en, data_valid, data_in, wrq_full,
    output wrreq, data_wr
  );
endinterface

// File: rtl/laser_rx_deframer.sv
// Parses START/LEN/payload/checksum frames from the laser link and drains verified payloads
// to the FTDI write queue. Optional error counter: define LASER_RX_DEFRAMER_STATS_EN.
module laser_rx_deframer #(
  parameter int         MAX_PAYLOAD = 64,
  parameter int         TIMEOUT     = 1024,
  parameter logic [7:0] START_BYTE  = 8'hCC,
  parameter logic [7:0] CLOSE_BYTE  = 8'h22
) (
  input  logic                clock,
  input  logic                reset,
  laser_rx_deframer_if.slave  bus,
  output logic                ack_pulse,
  output logic                fail_pulse,
  output logic                close_seen,
  output logic                busy,
  output logic [7:0]          err_count
);

  localparam int IW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t      r_state, w_state;
  logic [IW-1:0] r_wr_idx, w_wr_idx;
  logic [IW-1:0] r_rd_idx, w_rd_idx;
  logic [IW-1:0] r_len, w_len;
  logic [7:0]    r_csum, w_csum;
  logic [TW-1:0] r_tmo, w_tmo;
  logic          r_wrreq;
  logic [7:0]    r_data_wr;
  logic          r_ack, r_fail, r_close;
  logic          w_buf_we, w_rd_en, w_ack, w_fail, w_close;
  logic          w_len_bad;
  logic          w_tmo_hit;

  logic [7:0]    r_buf [MAX_PAYLOAD];

  assign w_len_bad = (bus.data_in == 8'h00) || ({1'b0, bus.data_in} > 9'(MAX_PAYLOAD));
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_state  = r_state;
    w_wr_idx = r_wr_idx;
    w_rd_idx = r_rd_idx;
    w_len    = r_len;
    w_csum   = r_csum;
    w_tmo    = r_tmo;
    w_buf_we = 1'b0;
    w_rd_en  = 1'b0;
    w_ack    = 1'b0;
    w_fail   = 1'b0;
    w_close  = 1'b0;
    if (!bus.en) begin
      // Disabled: abandon any frame or drain silently.
      w_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.data_valid) begin
            if (bus.data_in == START_BYTE) begin
              w_state = S_LEN;
              w_tmo   = '0;
            end else if (bus.data_in == CLOSE_BYTE) begin
              w_close = 1'b1;
            end
          end
        end
        S_LEN, S_PAYLOAD, S_CHECK: begin
          if (!bus.data_valid) begin
            if (w_tmo_hit) begin
              w_fail  = 1'b1;
              w_state = S_IDLE;
              w_tmo   = '0;
            end else begin
              w_tmo = r_tmo + TW'(1);
            end
          end else begin
            w_tmo = '0;
            if (r_state == S_LEN) begin
              if (w_len_bad) begin
                w_fail  = 1'b1;
                w_state = S_IDLE;
              end else begin
                w_len    = IW'(bus.data_in);
                w_csum   = bus.data_in;
                w_wr_idx = '0;
                w_state  = S_PAYLOAD;
              end
            end else if (r_state == S_PAYLOAD) begin
              w_buf_we = 1'b1;
              w_csum   = r_csum ^ bus.data_in;
              w_wr_idx = r_wr_idx + IW'(1);
              if (r_wr_idx == r_len - IW'(1)) begin
                w_state = S_CHECK;
              end
            end else begin
              if (bus.data_in == r_csum) begin
                w_ack    = 1'b1;
                w_rd_idx = '0;
                w_state  = S_DRAIN;
              end else begin
                w_fail  = 1'b1;
                w_state = S_IDLE;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!bus.wrq_full) begin
            w_rd_en  = 1'b1;
            w_rd_idx = r_rd_idx + IW'(1);
            if (r_rd_idx == r_len - IW'(1)) begin
              w_state = S_IDLE;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_len     <= '0;
      r_csum    <= '0;
      r_tmo     <= '0;
      r_wrreq   <= 1'b0;
      r_data_wr <= '0;
      r_ack     <= 1'b0;
      r_fail    <= 1'b0;
      r_close   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_wr_idx <= w_wr_idx;
      r_rd_idx <= w_rd_idx;
      r_len    <= w_len;
      r_csum   <= w_csum;
      r_tmo    <= w_tmo;
      r_wrreq  <= w_rd_en;
      r_ack    <= w_ack;
      r_fail   <= w_fail;
      r_close  <= w_close;
      // Registered buffer read doubles as the data_wr output register.
      if (w_rd_en) begin
        r_data_wr <= r_buf[r_rd_idx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_buf_we) begin
      r_buf[r_wr_idx[AW-1:0]] <= bus.data_in;
    end
  end

`ifdef LASER_RX_DEFRAMER_STATS_EN
  logic       w_overrun;
  logic [7:0] r_err;

  assign w_overrun = bus.en && (r_state == S_DRAIN) && bus.data_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= '0;
    end else if ((w_fail || w_overrun) && (r_err != 8'hFF)) begin
      r_err <= r_err + 8'd1;
    end
  end

  assign err_count = r_err;
`else
  assign err_count = 8'h00;
`endif

  assign bus.wrreq  = r_wrreq;
  assign bus.data_wr = r_data_wr;
  assign ack_pulse  = r_ack;
  assign fail_pulse = r_fail;
  assign close_seen = r_close;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_laser_rx_deframer.sv
// Directed bench for laser_rx_deframer: framing, checksum, length limits, backpressure,
// timeout, close, reset and enable handling.
`timescale 1ns/1ps
module tb_laser_rx_deframer;

`ifdef LASER_RX_DEFRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  laser_rx_deframer_if bus();

  logic       ack_pulse, fail_pulse, close_seen, busy;
  logic [7:0] err_count;

  laser_rx_deframer dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .ack_pulse  (ack_pulse),
    .fail_pulse (fail_pulse),
    .close_seen (close_seen),
    .busy       (busy),
    .err_count  (err_count)
  );

  int total = 0;
  int bad   = 0;
  int exp_err = 0;

  int ack_cnt = 0, fail_cnt = 0, close_cnt = 0, both_cnt = 0, wr_cnt = 0;
  logic [7:0] wr_log [256];
  logic [7:0] frm [$];

  always @(negedge clock) begin
    if (bus.wrreq === 1'b1) begin
      wr_log[wr_cnt[7:0]] <= bus.data_wr;
      wr_cnt <= wr_cnt + 1;
    end
    if (ack_pulse === 1'b1) ack_cnt <= ack_cnt + 1;
    if (fail_pulse === 1'b1) fail_cnt <= fail_cnt + 1;
    if (close_seen === 1'b1) close_cnt <= close_cnt + 1;
    if (ack_pulse === 1'b1 && fail_pulse === 1'b1) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    @(posedge clock); #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
    $display("frame sent: %0d bytes, first %h last %h", frm.size(), frm[0], frm[frm.size()-1]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    total++; if (bus.wrreq !== 1'b0) begin bad++; $display("FAIL reset_wrreq: got %b want 0", bus.wrreq); end
    total++; if (bus.data_wr !== 8'h00) begin bad++; $display("FAIL reset_data_wr: got %h want 00", bus.data_wr); end
    total++; if (ack_pulse !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack_pulse); end
    total++; if (fail_pulse !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", fail_pulse); end
    total++; if (close_seen !== 1'b0) begin bad++; $display("FAIL reset_close: got %b want 0", close_seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err_count !== 8'h00) begin bad++; $display("FAIL reset_err: got %h want 00", err_count); end
    reset = 1'b0;
    wait_cycles(2);
    $display("reset checked");
  endtask

  task automatic test_good_frame();
    int ws, fs, as, cs;
    ws = wr_cnt; fs = fail_cnt; as = ack_cnt; cs = close_cnt;
    frm = '{8'hCC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_frame();
    total++; if (ack_pulse !== 1'b1) begin bad++; $display("FAIL good_ack: got %b want 1", ack_pulse); end
    total++; if (bus.wrreq !== 1'b0) begin bad++; $display("FAIL good_wrreq_early: got %b want 0", bus.wrreq); end
    wait_cycles(1);
    total++; if (bus.wrreq !== 1'b1 || bus.data_wr !== 8'h11) begin bad++; $display("FAIL good_first_wr: got %b/%h want 1/11", bus.wrreq, bus.data_wr); end
    wait_cycles(6);
    total++; if (wr_cnt - ws !== 3) begin bad++; $display("FAIL good_wr_count: got %0d want 3", wr_cnt - ws); end
    total++; if (wr_log[ws[7:0]] !== 8'h11 || wr_log[8'(ws+1)] !== 8'h22 || wr_log[8'(ws+2)] !== 8'h33) begin
      bad++; $display("FAIL good_wr_data: got %h %h %h want 11 22 33", wr_log[ws[7:0]], wr_log[8'(ws+1)], wr_log[8'(ws+2)]);
    end
    total++; if (ack_cnt - as !== 1 || fail_cnt - fs !== 0) begin bad++; $display("FAIL good_pulses: got ack %0d fail %0d want 1 0", ack_cnt - as, fail_cnt - fs); end
    total++; if (close_cnt - cs !== 0) begin bad++; $display("FAIL good_no_close: got %0d want 0", close_cnt - cs); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_bad_checksum();
    int ws;
    ws = wr_cnt;
    frm = '{8'hCC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_frame();
    exp_err++;
    total++; if (fail_pulse !== 1'b1 || ack_pulse !== 1'b0) begin bad++; $display("FAIL badsum_pulse: got fail %b ack %b want 1 0", fail_pulse, ack_pulse); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badsum_busy: got %b want 0", busy); end
    wait_cycles(1);
    total++; if (fail_pulse !== 1'b0) begin bad++; $display("FAIL badsum_one_cycle: got %b want 0", fail_pulse); end
    wait_cycles(4);
    total++; if (wr_cnt - ws !== 0) begin bad++; $display("FAIL badsum_no_wr: got %0d want 0", wr_cnt - ws); end
    total++; if (err_count !== 8'(STATS ? exp_err : 0)) begin bad++; $display("FAIL badsum_err: got %0d want %0d", err_count, STATS ? exp_err : 0); end
  endtask

  task automatic test_length();
    int ws;
    frm = '{8'hCC, 8'h00};
    send_frame();
    exp_err++;
    total++; if (fail_pulse !== 1'b1) begin bad++; $display("FAIL len_zero: got %b want 1", fail_pulse); end
    frm = '{8'hCC, 8'h41};
    send_frame();
    exp_err++;
    total++; if (fail_pulse !== 1'b1) begin bad++; $display("FAIL len_over: got %b want 1", fail_pulse); end
    ws = wr_cnt;
    frm = '{8'hCC, 8'h01, 8'h5A, 8'h5B};
    send_frame();
    total++; if (ack_pulse !== 1'b1) begin bad++; $display("FAIL len_one_ack: got %b want 1", ack_pulse); end
    wait_cycles(4);
    total++; if (wr_cnt - ws !== 1 || wr_log[ws[7:0]] !== 8'h5A) begin bad++; $display("FAIL len_one_wr: got %0d/%h want 1/5a", wr_cnt - ws, wr_log[ws[7:0]]); end
    total++; if (err_count !== 8'(STATS ? exp_err : 0)) begin bad++; $display("FAIL len_err: got %0d want %0d", err_count, STATS ? exp_err : 0); end
  endtask

  task automatic test_backpressure();
    int ws, hits;
    ws = wr_cnt; hits = 0;
    frm = '{8'hCC, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00};
    send_frame();
    total++; if (ack_pulse !== 1'b1) begin bad++; $display("FAIL bp_ack: got %b want 1", ack_pulse); end
    wait_cycles(1);
    bus.wrq_full = 1'b1;
    total++; if (bus.wrreq !== 1'b1 || bus.data_wr !== 8'hA1) begin bad++; $display("FAIL bp_first: got %b/%h want 1/a1", bus.wrreq, bus.data_wr); end
    for (int i = 0; i < 10; i++) begin
      wait_cycles(1);
      if (bus.wrreq === 1'b1) hits++;
    end
    bus.wrq_full = 1'b0;
    total++; if (hits !== 0) begin bad++; $display("FAIL bp_stall: got %0d requests want 0", hits); end
    wait_cycles(6);
    total++; if (wr_cnt - ws !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", wr_cnt - ws); end
    total++; if (wr_log[ws[7:0]] !== 8'hA1 || wr_log[8'(ws+1)] !== 8'hB2 || wr_log[8'(ws+2)] !== 8'hC3 || wr_log[8'(ws+3)] !== 8'hD4) begin
      bad++; $display("FAIL bp_order: got %h %h %h %h want a1 b2 c3 d4", wr_log[ws[7:0]], wr_log[8'(ws+1)], wr_log[8'(ws+2)], wr_log[8'(ws+3)]);
    end
  endtask

  task automatic test_timeout();
    int ws;
    frm = '{8'hCC, 8'h02, 8'hAA};
    send_frame();
    wait_cycles(1023);
    total++; if (fail_pulse !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early: got fail %b busy %b want 0 1", fail_pulse, busy); end
    wait_cycles(1);
    exp_err++;
    total++; if (fail_pulse !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL tmo_fire: got fail %b busy %b want 1 0", fail_pulse, busy); end
    ws = wr_cnt;
    frm = '{8'hCC, 8'h01, 8'h5A, 8'h5B};
    send_frame();
    total++; if (ack_pulse !== 1'b1) begin bad++; $display("FAIL tmo_next_ack: got %b want 1", ack_pulse); end
    wait_cycles(4);
    total++; if (wr_cnt - ws !== 1 || wr_log[ws[7:0]] !== 8'h5A) begin bad++; $display("FAIL tmo_next_wr: got %0d/%h want 1/5a", wr_cnt - ws, wr_log[ws[7:0]]); end
    total++; if (err_count !== 8'(STATS ? exp_err : 0)) begin bad++; $display("FAIL tmo_err: got %0d want %0d", err_count, STATS ? exp_err : 0); end
  endtask

  task automatic test_close();
    frm = '{8'h22};
    send_frame();
    total++; if (close_seen !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL close_pulse: got %b busy %b want 1 0", close_seen, busy); end
    wait_cycles(1);
    total++; if (close_seen !== 1'b0) begin bad++; $display("FAIL close_one_cycle: got %b want 0", close_seen); end
    bus.en = 1'b0;
    send_byte(8'h22);
    total++; if (close_seen !== 1'b0) begin bad++; $display("FAIL close_disabled: got %b want 0", close_seen); end
    bus.en = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_reset_mid();
    int as, fs;
    frm = '{8'hCC, 8'h03, 8'h11};
    send_frame();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    wait_cycles(1);
    total++; if (busy !== 1'b0 || bus.wrreq !== 1'b0 || bus.data_wr !== 8'h00) begin
      bad++; $display("FAIL rstmid_outputs: got busy %b wrreq %b data %h want 0 0 00", busy, bus.wrreq, bus.data_wr);
    end
    total++; if (ack_pulse !== 1'b0 || fail_pulse !== 1'b0 || close_seen !== 1'b0 || err_count !== 8'h00) begin
      bad++; $display("FAIL rstmid_flags: got ack %b fail %b close %b err %h want 0 0 0 00", ack_pulse, fail_pulse, close_seen, err_count);
    end
    reset = 1'b0;
    exp_err = 0;
    as = ack_cnt; fs = fail_cnt;
    wait_cycles(5);
    total++; if (ack_cnt - as !== 0 || fail_cnt - fs !== 0) begin bad++; $display("FAIL rstmid_no_pulse: got ack %0d fail %0d want 0 0", ack_cnt - as, fail_cnt - fs); end
  endtask

  task automatic test_en_overrun();
    int ws, as, fs;
    ws = wr_cnt; as = ack_cnt; fs = fail_cnt;
    bus.wrq_full = 1'b1;
    frm = '{8'hCC, 8'h01, 8'h77, 8'h76};
    send_frame();
    total++; if (ack_pulse !== 1'b1) begin bad++; $display("FAIL en_ack: got %b want 1", ack_pulse); end
    send_byte(8'h55);
    exp_err++;
    total++; if (busy !== 1'b1 || bus.wrreq !== 1'b0) begin bad++; $display("FAIL en_stalled: got busy %b wrreq %b want 1 0", busy, bus.wrreq); end
    bus.en = 1'b0;
    wait_cycles(1);
    total++; if (busy !== 1'b0 || ack_pulse !== 1'b0 || fail_pulse !== 1'b0) begin
      bad++; $display("FAIL en_abort: got busy %b ack %b fail %b want 0 0 0", busy, ack_pulse, fail_pulse);
    end
    bus.wrq_full = 1'b0;
    wait_cycles(3);
    bus.en = 1'b1;
    wait_cycles(5);
    total++; if (wr_cnt - ws !== 0) begin bad++; $display("FAIL en_dropped: got %0d writes want 0", wr_cnt - ws); end
    total++; if (ack_cnt - as !== 1 || fail_cnt - fs !== 0) begin bad++; $display("FAIL en_pulses: got ack %0d fail %0d want 1 0", ack_cnt - as, fail_cnt - fs); end
    total++; if (err_count !== 8'(STATS ? exp_err : 0)) begin bad++; $display("FAIL en_overrun_err: got %0d want %0d", err_count, STATS ? exp_err : 0); end
    ws = wr_cnt;
    frm = '{8'hCC, 8'h01, 8'h5A, 8'h5B};
    send_frame();
    wait_cycles(4);
    total++; if (wr_cnt - ws !== 1 || wr_log[ws[7:0]] !== 8'h5A) begin bad++; $display("FAIL en_recover: got %0d/%h want 1/5a", wr_cnt - ws, wr_log[ws[7:0]]); end
  endtask

  task automatic test_exclusive();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL ack_fail_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    bus.en         = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    bus.wrq_full   = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length();
    test_backpressure();
    test_timeout();
    test_close();
    test_reset_mid();
    test_en_overrun();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
